// File: rtl/spi_master.sv
// rtl/spi_master.sv - Mode-0 byte SPI master with burst chip-select hold
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold_cs,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD, ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              phase_end;

  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = phase_end ? '0 : div_q + 1'b1;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        div_d = '0;
        if (start) begin
          tx_sh_d = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = ST_SETUP;
        end else if (state_q == ST_HOLD && !hold_cs) begin
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          sck_d   = 1'b0;
          state_d = ST_LOW;
          // the last bit stays on mosi through the final low phase
          if (bit_q != BIT_LAST) begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[DATA_W-2];
          end
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          if (bit_q == BIT_LAST) begin
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            if (hold_cs) begin
              busy_d  = 1'b0;
              state_d = ST_HOLD;
            end else begin
              cs_d    = 1'b1;
              state_d = ST_GAP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            sck_d   = 1'b1;
            state_d = ST_HIGH;
          end
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - Self-checking bench for spi_master against a byte-level SPI model
module tb_spi_master;

  localparam int CD = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, hold_cs, miso, busy, done, cs, sck, mosi;
  logic [7:0] tx_data, rx_data;
  logic       start1, busy1, done1, cs1, sck1, mosi1;
  logic [7:0] tx1, rx1;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int falls = 0;
  int dones = 0;
  int sck_cs_hi = 0;
  int falls_base = 0;
  logic [7:0] mosi_seq = 8'h00;
  logic       loop_mode = 1'b1;
  logic [7:0] pat = 8'h00;

  spi_master #(.CLK_DIV(CD), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold_cs(hold_cs), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .cs(cs), .sck(sck),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(1), .DATA_W(DW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold_cs(1'b0), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1), .cs(cs1), .sck(sck1),
    .mosi(mosi1), .miso(mosi1)
  );

  // Slave model: either loopback, or a pattern byte shifted out MSB first, advancing on each sck fall
  always_comb begin
    int k;
    k = 7 - (falls - falls_base);
    if (loop_mode)         miso = mosi;
    else if (k >= 0 && k < 8) miso = pat[k[2:0]];
    else                   miso = 1'b0;
  end

  always @(posedge sck) begin
    rises++;
    mosi_seq = {mosi_seq[6:0], mosi};
    if (cs) sck_cs_hi++;
  end
  always @(negedge sck) falls++;
  always @(posedge clk) if (done) dones++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [7:0] tx, input logic hold, input logic inject,
                       input logic [7:0] exp_rx);
    int   lat, r0, gap;
    logic cs_broke, gap_cs_ok;
    r0 = rises;
    cs_broke = 1'b0;
    @(negedge clk);
    falls_base = falls;
    tx_data = tx; hold_cs = hold; start = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_cs", cs, 0);
    @(negedge clk);
    start = 1'b0;
    tx_data = 8'($urandom);
    for (lat = 1; lat <= 400; lat++) begin
      @(posedge clk); #1;
      if (inject) begin
        if (lat == 20) begin start = 1'b1; tx_data = 8'h3C; end
        else start = 1'b0;
      end
      if (done) break;
      if (cs) cs_broke = 1'b1;
    end
    start = 1'b0;
    check("done_latency", lat, (2 * DW + 1) * CD);
    check("cs_low_frame", cs_broke, 0);
    check("sck_rises", rises - r0, DW);
    check("mosi_bits", mosi_seq, tx);
    check("rx_data", rx_data, exp_rx);
    if (!hold) begin
      gap = 1;
      gap_cs_ok = cs;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        if (!busy) break;
        gap++;
        if (!cs) gap_cs_ok = 1'b0;
      end
      check("gap_len", gap, CD);
      check("gap_cs_high", gap_cs_ok, 1);
      check("idle_cs", cs, 1);
    end else begin
      check("hold_cs_low", cs, 0);
      check("hold_not_busy", busy, 0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int   r0, d0, lat, i;
    logic [7:0] t;
    rst = 1'b0; start = 1'b0; hold_cs = 1'b0; tx_data = 8'h00;
    start1 = 1'b0; tx1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 8'h00);

    loop_mode = 1'b1;
    frame(8'hA5, 1'b0, 1'b0, 8'hA5);

    loop_mode = 1'b0; pat = 8'hFF;
    frame(8'h00, 1'b0, 1'b0, 8'hFF);

    for (int n = 0; n < 6; n++) begin
      t = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        loop_mode = 1'b1;
        frame(t, 1'b0, 1'b0, t);
      end else begin
        loop_mode = 1'b0;
        pat = 8'($urandom);
        frame(t, 1'b0, 1'b0, pat);
      end
    end
    loop_mode = 1'b1;

    // Burst with cs held across two bytes
    r0 = rises; d0 = dones;
    frame(8'hAA, 1'b1, 1'b0, 8'hAA);
    repeat (5) @(posedge clk);
    #1;
    check("burst_hold_cs", cs, 0);
    frame(8'h55, 1'b1, 1'b0, 8'h55);
    repeat (5) @(posedge clk);
    #1;
    check("burst_hold_cs2", cs, 0);
    @(negedge clk) hold_cs = 1'b0;
    @(posedge clk); #1;
    check("release_cs", cs, 1);
    check("release_busy", busy, 1);
    for (i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    check("release_idle", i < 50, 1);
    check("burst_rises", rises - r0, 2 * DW);
    check("burst_dones", dones - d0, 2);

    // start pulse mid-frame must be ignored
    r0 = rises; d0 = dones;
    frame(8'hC3, 1'b0, 1'b1, 8'hC3);
    repeat (30) @(posedge clk);
    #1;
    check("busyprot_idle", busy, 0);
    check("busyprot_dones", dones - d0, 1);
    check("busyprot_rises", rises - r0, DW);

    // Asynchronous reset in the middle of a frame
    r0 = rises;
    @(negedge clk); tx_data = 8'hE7; hold_cs = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rises - r0 >= 3) break;
    end
    check("rst_mid_reach", i < 200, 1);
    @(negedge clk);
    check("pre_rst_sck", sck, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_cs", cs, 1);
    check("rst_mid_sck", sck, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    frame(8'h81, 1'b0, 1'b0, 8'h81);

    // CLK_DIV=1 instance
    @(negedge clk); tx1 = 8'h5A; start1 = 1'b1;
    @(posedge clk); #1;
    check("div1_busy", busy1, 1);
    @(negedge clk); start1 = 1'b0; tx1 = 8'h00;
    for (lat = 1; lat <= 100; lat++) begin
      @(posedge clk); #1;
      if (done1) break;
    end
    check("div1_latency", lat, 2 * DW + 1);
    check("div1_rx", rx1, 8'h5A);
    repeat (5) @(posedge clk);
    #1;
    check("div1_idle_cs", cs1, 1);
    check("div1_idle_busy", busy1, 0);

    check("sck_while_cs_high", sck_cs_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
